// File: rtl/mem_access_unit.sv
// Load/store memory access sequencer: accepts one request, runs the word-aligned
// memory handshake, formats store data/byte-enables and captures load data.
module mem_access_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byte_enable,
    input  logic        mem_resp,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mdrreg_out,
    output logic [1:0]  mem_offset,
    output logic        done,
    output logic        misaligned
);

    localparam int unsigned WordW = 32;
    localparam int unsigned BeW   = WordW / 8;

    typedef logic [WordW-1:0] rv32i_word;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    rv32i_word       addr_q, wdata_q, mdr_q;
    logic [1:0]      offset_q;
    logic [BeW-1:0]  be_q;
    logic            misaligned_q;

    logic            accept_c;
    logic            err_c;
    logic [BeW-1:0]  be_c;
    rv32i_word       wdata_c;

    assign accept_c = req_valid && (state_q == S_IDLE);

    // Store lane formatting and alignment/legality check of the incoming request.
    always_comb begin
        err_c   = 1'b0;
        be_c    = '0;
        wdata_c = req_wdata;
        if (req_store) begin
            case (req_funct3)
                3'b000: begin
                    be_c    = BeW'(4'b0001 << req_addr[1:0]);
                    wdata_c = {4{req_wdata[7:0]}};
                end
                3'b001: begin
                    be_c    = BeW'(4'b0011 << req_addr[1:0]);
                    wdata_c = {2{req_wdata[15:0]}};
                    err_c   = req_addr[0];
                end
                3'b010: begin
                    be_c  = 4'b1111;
                    err_c = |req_addr[1:0];
                end
                default: err_c = 1'b1;
            endcase
        end else begin
            case (req_funct3)
                3'b000, 3'b100: err_c = 1'b0;
                3'b001, 3'b101: err_c = req_addr[0];
                3'b010:         err_c = |req_addr[1:0];
                default:        err_c = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and Moore decode of the handshake strobes.
    always_comb begin
        state_d         = state_q;
        req_ready       = 1'b0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        done            = 1'b0;
        mem_byte_enable = '0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (err_c) begin
                        state_d = S_DONE;
                    end else if (req_store) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                mem_read = 1'b1;
                if (mem_resp) state_d = S_DONE;
            end
            S_WRITE: begin
                mem_write       = 1'b1;
                mem_byte_enable = be_q;
                if (mem_resp) state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Request capture on accept; everything holds until the next accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q       <= '0;
            offset_q     <= '0;
            be_q         <= '0;
            wdata_q      <= '0;
            misaligned_q <= 1'b0;
        end else if (accept_c) begin
            addr_q       <= {req_addr[31:2], 2'b00};
            offset_q     <= req_addr[1:0];
            be_q         <= be_c;
            wdata_q      <= wdata_c;
            misaligned_q <= err_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdr_q <= '0;
        end else if ((state_q == S_READ) && mem_resp) begin
            mdr_q <= mem_rdata;
        end
    end

    assign mem_address = addr_q;
    assign mem_wdata   = wdata_q;
    assign mem_offset  = offset_q;
    assign mdrreg_out  = mdr_q;
    assign misaligned  = misaligned_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with hand-computed expectations.
module tb_mem_access_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_enable;
    logic        mem_resp;
    logic [31:0] mem_rdata;
    logic [31:0] mdrreg_out;
    logic [1:0]  mem_offset;
    logic        done;
    logic        misaligned;

    int n_vec = 0;
    int n_err = 0;

    int          lat, strb;
    logic [31:0] addr_seen, wd_seen;
    logic [3:0]  be_seen;
    logic        rdy_seen;

    mem_access_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_store       (req_store),
        .req_funct3      (req_funct3),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_wdata       (mem_wdata),
        .mem_byte_enable (mem_byte_enable),
        .mem_resp        (mem_resp),
        .mem_rdata       (mem_rdata),
        .mdrreg_out      (mdrreg_out),
        .mem_offset      (mem_offset),
        .done            (done),
        .misaligned      (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one request from IDLE; a memory model answers after 'waits' strobe cycles.
    // Returns in the DONE cycle (or after a bounded number of cycles).
    task automatic access(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int waits, input logic [31:0] rd);
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        addr_seen  = '0;
        wd_seen    = '0;
        be_seen    = '0;
        rdy_seen   = 1'b0;
        tick;
        req_valid = 1'b0;
        lat  = 1;
        strb = 0;
        while (!done && lat < 20) begin
            rdy_seen = rdy_seen | req_ready;
            if (mem_read || mem_write) begin
                strb++;
                addr_seen = mem_address;
                wd_seen   = mem_wdata;
                be_seen   = mem_byte_enable;
                if (strb > waits) begin
                    mem_resp  = 1'b1;
                    mem_rdata = rd;
                end
            end
            tick;
            mem_resp = 1'b0;
            lat++;
        end
    endtask

    initial begin
        int first_wr, n_done;
        logic rdy_early, rdy_idle, rd_first;

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_store  = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = '0;
        req_wdata  = '0;
        mem_resp   = 1'b0;
        mem_rdata  = '0;
        #1;
        check("rst_ready", req_ready, 1);
        check("rst_read", mem_read, 0);
        check("rst_write", mem_write, 0);
        check("rst_done", done, 0);
        check("rst_mis", misaligned, 0);
        check("rst_mdr", mdrreg_out, 0);
        check("rst_addr", mem_address, 0);
        check("rst_be", mem_byte_enable, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_off", mem_offset, 0);
        tick;
        tick;
        rst_n = 1'b1;
        tick;

        // lw 0x1000, two wait cycles
        access(1'b0, 3'b010, 32'h0000_1000, 32'h0, 2, 32'hDEAD_BEEF);
        check("lw_lat", lat, 4);
        check("lw_strobe_cycles", strb, 3);
        check("lw_addr", addr_seen, 32'h0000_1000);
        check("lw_done", done, 1);
        check("lw_mdr", mdrreg_out, 32'hDEAD_BEEF);
        check("lw_off", mem_offset, 0);
        check("lw_mis", misaligned, 0);
        check("lw_ready_busy", rdy_seen, 0);
        check("lw_done_ready", req_ready, 0);
        tick;

        // sb 0x2003, immediate response
        access(1'b1, 3'b000, 32'h0000_2003, 32'h0000_00A5, 0, 32'h0BAD_0BAD);
        check("sb_lat", lat, 2);
        check("sb_strobe_cycles", strb, 1);
        check("sb_addr", addr_seen, 32'h0000_2000);
        check("sb_be", be_seen, 4'b1000);
        check("sb_wdata", wd_seen, 32'hA5A5_A5A5);
        check("sb_mdr_hold", mdrreg_out, 32'hDEAD_BEEF);
        check("sb_off", mem_offset, 3);
        tick;

        // sh 0x3002, one wait cycle
        access(1'b1, 3'b001, 32'h0000_3002, 32'h1234_BEEF, 1, 32'h0);
        check("sh_lat", lat, 3);
        check("sh_be", be_seen, 4'b1100);
        check("sh_wdata", wd_seen, 32'hBEEF_BEEF);
        check("sh_addr", addr_seen, 32'h0000_3000);
        check("sh_be_after", mem_byte_enable, 0);
        tick;

        // misaligned lw 0x4001
        access(1'b0, 3'b010, 32'h0000_4001, 32'h0, 0, 32'h0);
        check("mis_lw_lat", lat, 1);
        check("mis_lw_strobe", strb, 0);
        check("mis_lw_done", done, 1);
        check("mis_lw_flag", misaligned, 1);
        tick;
        check("mis_lw_hold", misaligned, 1);

        // misaligned lh 0x4003
        access(1'b0, 3'b001, 32'h0000_4003, 32'h0, 0, 32'h0);
        check("mis_lh_lat", lat, 1);
        check("mis_lh_strobe", strb, 0);
        check("mis_lh_flag", misaligned, 1);
        check("mis_lh_mdr_hold", mdrreg_out, 32'hDEAD_BEEF);
        tick;

        // lbu 0x4003 is legal
        access(1'b0, 3'b100, 32'h0000_4003, 32'h0, 0, 32'h1122_3344);
        check("lbu_lat", lat, 2);
        check("lbu_off", mem_offset, 3);
        check("lbu_mis", misaligned, 0);
        check("lbu_mdr", mdrreg_out, 32'h1122_3344);
        check("lbu_addr", addr_seen, 32'h0000_4000);
        tick;

        // illegal funct3 on a load and on a store
        access(1'b0, 3'b011, 32'h0000_5000, 32'h0, 0, 32'h0);
        check("ill_ld_lat", lat, 1);
        check("ill_ld_flag", misaligned, 1);
        tick;
        access(1'b1, 3'b100, 32'h0000_5000, 32'h0, 0, 32'h0);
        check("ill_st_strobe", strb, 0);
        check("ill_st_flag", misaligned, 1);
        tick;

        // reset in the middle of a read wait
        req_valid  = 1'b1;
        req_store  = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h0000_6000;
        tick;
        req_valid = 1'b0;
        tick;
        check("rstmid_read_pre", mem_read, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid_read_drop", mem_read, 0);
        check("rstmid_ready", req_ready, 1);
        check("rstmid_mdr", mdrreg_out, 0);
        check("rstmid_addr", mem_address, 0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        mem_resp = 1'b1;
        tick;
        mem_resp = 1'b0;
        n_done = 0;
        for (int c = 0; c < 3; c++) begin
            if (done) n_done++;
            tick;
        end
        check("rstmid_no_done", n_done, 0);
        check("rstmid_ready_after", req_ready, 1);

        // back-to-back lw then sw with req_valid held high
        req_valid  = 1'b1;
        req_store  = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h0000_7000;
        mem_rdata  = 32'h55AA_55AA;
        tick;
        req_store  = 1'b1;
        req_addr   = 32'h0000_7004;
        req_wdata  = 32'hCAFE_F00D;
        first_wr   = 0;
        n_done     = 0;
        rdy_early  = 1'b0;
        rdy_idle   = 1'b0;
        rd_first   = 1'b0;
        wd_seen    = '0;
        be_seen    = '0;
        for (int c = 1; c <= 6; c++) begin
            if (c < 3 && req_ready) rdy_early = 1'b1;
            if (c == 3) rdy_idle = req_ready;
            if (c == 1) rd_first = mem_read;
            if (done) n_done++;
            if (mem_write && first_wr == 0) begin
                first_wr = c;
                wd_seen  = mem_wdata;
                be_seen  = mem_byte_enable;
            end
            if (c == 5) req_valid = 1'b0;
            mem_resp = mem_read | mem_write;
            tick;
            mem_resp = 1'b0;
        end
        check("b2b_read_first", rd_first, 1);
        check("b2b_ready_busy", rdy_early, 0);
        check("b2b_ready_idle", rdy_idle, 1);
        check("b2b_write_cycle", first_wr, 4);
        check("b2b_done_count", n_done, 2);
        check("b2b_mdr", mdrreg_out, 32'h55AA_55AA);
        check("b2b_wdata", wd_seen, 32'hCAFE_F00D);
        check("b2b_be", be_seen, 4'b1111);
        check("b2b_addr", mem_address, 32'h0000_7004);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
